modarith_arbiter: RTL and testbench
===================================

Name: modarith_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one registered modular add/sub datapath among NUM_REQ requesters.
- Holds the modulus in a configuration register, grants one operation per cycle and returns a tagged, registered result through a valid/ready response port.
- Sits between the ECC point-arithmetic sequencers and the field add/sub logic.

Parameters:
DATA_WIDTH, 256, operand/modulus/result width
NUM_REQ, 4, number of requesters (≥2)
ID_W, 2, width of requester tag (clog2(NUM_REQ))

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mod_ld  in  1  request to load new modulus
mod_in  in  DATA_WIDTH  modulus value to load
mod_ld_ack  out  1  modulus accepted this cycle
req_valid  in  NUM_REQ  per-requester operation valid
req_ready  out  NUM_REQ  per-requester grant, one-hot or zero
req_op  in  NUM_REQ  per-requester op: 0 = sub (a−b mod M), 1 = add (a+b mod M)
req_a  in  NUM_REQ*DATA_WIDTH  operand A, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_b  in  NUM_REQ*DATA_WIDTH  operand B, same packing
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_id  out  ID_W  index of requester that issued the result
rsp_data  out  DATA_WIDTH  result
rsp_err  out  1  operand range error (MODARITH_RANGE_CHK_EN only, else tied 0)

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, mod_reg=0, rr_ptr=0, state=EMPTY. req_ready and mod_ld_ack are combinational and stay 0 while rst=1.
- FSM on the result register:
  - EMPTY: no result held.
  - FULL: rsp_valid=1.
  - EMPTY→FULL on grant.
  - FULL→EMPTY on rsp_ready with no grant.
  - FULL→FULL on rsp_ready with a grant (back-to-back).
- Slot free: free = (state==EMPTY) | rsp_ready.
- Grant:
  - Only when free and mod_ld=0.
  - Scan req_valid starting at rr_ptr, wrapping at NUM_REQ−1→0; the first set bit wins; req_ready[winner]=1.
  - On grant, rr_ptr ← (winner+1) mod NUM_REQ; otherwise rr_ptr holds.
- Handshake:
  - Transfer occurs when req_valid[i] & req_ready[i].
  - Requester holds valid, op, a and b stable until the transfer.
  - req_ready never depends on the asserting requester's own data.
- Latency: 1 cycle. Result is registered the cycle after the grant: rsp_valid=1, rsp_id=winner, rsp_data=f(a,b,M).
- rsp_data, rsp_id and rsp_err hold stable while rsp_valid & ~rsp_ready.
- Arithmetic (M = mod_reg; requires a<M, b<M):
  - sub: a≥b → a−b; else a+M−b, computed in DATA_WIDTH+1 bits. a==b gives 0.
  - add: s=a+b in DATA_WIDTH+1 bits; s≥M → s−M, else s.
  - Result is always truncated to DATA_WIDTH.
- Modulus load:
  - mod_ld_ack = mod_ld & (state==EMPTY); mod_reg ← mod_in that cycle.
  - While mod_ld=1, no grants are issued. This drains a FULL slot: the held result completes with the old M, then the load proceeds.
  - mod_ld held high starves requesters; this is intended.
- Simultaneous events:
  - Consume plus grant in the same cycle loads the new result with no bubble.
  - mod_ld plus rsp_ready while FULL: the slot drains that cycle; ack comes next cycle.
- Reset mid-operation discards the held result and the pending grant; mod_reg returns to 0, and software reloads it.
- M=0 is not checked; the result is undefined.

Optional Feature:
- Macro: MODARITH_RANGE_CHK_EN.
- Defined:
  - At grant, rsp_err is registered = (a≥M) | (b≥M), alongside the result.
  - rsp_data is still computed as specified.
  - rsp_err follows the same hold rules as rsp_data.
- Undefined: rsp_err is constant 0 and no comparators are synthesized.

Decomposition:
- Package modarith_pkg holds:
  - OP_SUB=1'b0, OP_ADD=1'b1.
  - State encoding EMPTY=1'b0, FULL=1'b1.
  - Default DATA_WIDTH.
- Sub-module modarith_core: combinational (a, b, M, op) → result. Holds the add/sub/compare logic, instantiated once.
- The arbiter, rr_ptr, FSM and modulus register live in the top module.

Test Plan (DATA_WIDTH=8, NUM_REQ=4, M=97):
- Load M=97 from EMPTY → mod_ld_ack=1 same cycle; req0 sub a=10,b=20 → next cycle rsp_valid=1, rsp_id=0, rsp_data=87.
- req2 add a=90,b=20 → 13; add a=40,b=50 → 90; sub a=33,b=33 → 0; sub a=0,b=96 → 1.
- All four req_valid held high, rsp_ready=1 → grants 0,1,2,3,0,1 on consecutive cycles, one result per cycle, rsp_id in the same order.
- rsp_ready=0 for 3 cycles while FULL → req_ready all 0, rsp_data and rsp_id stable; rsp_ready=1 → same-cycle new grant, no bubble.
- mod_ld=1 (mod_in=89) while FULL, rsp_ready=1 → held result uses M=97, ack next cycle; a following sub 10−20 → 79.
- rst asserted while FULL with valid requests → next cycle rsp_valid=0, rr_ptr=0; first grant after release goes to req0. With MODARITH_RANGE_CHK_EN: add a=97,b=1 → rsp_err=1.

Source files
------------

// File: rtl/modarith_pkg.sv
// modarith_pkg
// Shared definitions for the modular add/sub arbiter slice:
//   - operation encoding carried on req_op (OP_SUB / OP_ADD)
//   - result-slot state encoding (EMPTY / FULL)
//   - default operand width
// Imported by modarith_arbiter_if, modarith_core and modarith_arbiter.
package modarith_pkg;

  localparam int DEFAULT_DATA_WIDTH = 256;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/modarith_arbiter_if.sv
// modarith_arbiter_if
// Bundles the modulus-load, request and response signals of the shared
// modular add/sub datapath.
//   master modport : requester/software side (drives requests, modulus loads,
//                    rsp_ready; observes grants, acks and results)
//   slave modport  : modarith_arbiter side
// Signals:
//   mod_ld, mod_in, mod_ld_ack           modulus configuration handshake
//   req_valid, req_ready, req_op,
//   req_a, req_b                         per-requester operation handshake,
//                                        operands packed DATA_WIDTH per slot
//   rsp_valid, rsp_ready, rsp_id,
//   rsp_data, rsp_err                    tagged result handshake
interface modarith_arbiter_if
  import modarith_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2
);

  logic                          mod_ld;
  logic [DATA_WIDTH-1:0]         mod_in;
  logic                          mod_ld_ack;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_op;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_W-1:0]               rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_err;

  modport master (
    output mod_ld, mod_in, req_valid, req_op, req_a, req_b, rsp_ready,
    input  mod_ld_ack, req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  mod_ld, mod_in, req_valid, req_op, req_a, req_b, rsp_ready,
    output mod_ld_ack, req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/modarith_core.sv
// modarith_core
// Purely combinational modular add/sub of two operands already reduced
// below the modulus.
//   a, b   : operands (expected < m)
//   m      : modulus
//   op     : OP_SUB -> (a - b) mod m, OP_ADD -> (a + b) mod m
//   result : reduced result, DATA_WIDTH bits
module modarith_core
  import modarith_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] m,
  input  logic                  op,
  output logic [DATA_WIDTH-1:0] result
);

  // One extra bit so a+b and a+m-b cannot overflow before reduction.
  logic [DATA_WIDTH:0] a_x;
  logic [DATA_WIDTH:0] b_x;
  logic [DATA_WIDTH:0] m_x;
  logic [DATA_WIDTH:0] sum_x;

  assign a_x   = {1'b0, a};
  assign b_x   = {1'b0, b};
  assign m_x   = {1'b0, m};
  assign sum_x = a_x + b_x;

  // A single conditional subtraction (add) or addition (sub) of m is enough
  // because both operands are below m.
  always_comb begin
    result = '0;
    if (op == OP_ADD) begin
      if (sum_x >= m_x) result = DATA_WIDTH'(sum_x - m_x);
      else              result = DATA_WIDTH'(sum_x);
    end else begin
      if (a >= b) result = DATA_WIDTH'(a_x - b_x);
      else        result = DATA_WIDTH'(a_x + m_x - b_x);
    end
  end

endmodule

// File: rtl/modarith_arbiter.sv
// modarith_arbiter
// Round-robin arbiter sharing one modular add/sub datapath among NUM_REQ
// requesters. One operation is granted per cycle into a single registered
// result slot, returned with the requester tag over a valid/ready port.
// The modulus lives in a configuration register loaded via mod_ld; loads
// block grants and only complete once the result slot is empty.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : modarith_arbiter_if.slave (modulus load, requests, response)
// Build option:
//   MODARITH_RANGE_CHK_EN - when defined, rsp_err flags a granted operand
//   that is not below the modulus; otherwise rsp_err is tied low.
module modarith_arbiter
  import modarith_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2
) (
  input logic                clk,
  input logic                rst,
  modarith_arbiter_if.slave  bus
);

  state_t                state, state_nxt;
  logic [ID_W-1:0]       rr_ptr;
  logic [DATA_WIDTH-1:0] mod_reg;
  logic [ID_W-1:0]       rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  logic                  free;
  logic                  found;
  logic                  grant;
  logic [ID_W-1:0]       winner;
  logic [DATA_WIDTH-1:0] a_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] a_sel;
  logic [DATA_WIDTH-1:0] b_sel;
  logic                  op_sel;
  logic [DATA_WIDTH-1:0] core_result;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = bus.req_a[g*DATA_WIDTH +: DATA_WIDTH];
    assign b_arr[g] = bus.req_b[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan from rr_ptr upwards with wrap; the first valid requester wins.
  always_comb begin
    int idx;
    logic [ID_W-1:0] cand;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign a_sel  = a_arr[winner];
  assign b_sel  = b_arr[winner];
  assign op_sel = bus.req_op[winner];

  modarith_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .a      (a_sel),
    .b      (b_sel),
    .m      (mod_reg),
    .op     (op_sel),
    .result (core_result)
  );

  // Slot-free / grant / load-ack decisions and next state of the result
  // slot. A pending modulus load suppresses grants so the slot drains.
  always_comb begin
    free           = (state == EMPTY) | bus.rsp_ready;
    grant          = free & ~bus.mod_ld & found & ~rst;
    bus.mod_ld_ack = bus.mod_ld & (state == EMPTY) & ~rst;
    bus.req_ready  = '0;
    if (grant) bus.req_ready[winner] = 1'b1;

    state_nxt = state;
    case (state)
      EMPTY:   if (grant) state_nxt = FULL;
      FULL:    if (bus.rsp_ready && !grant) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // State, pointer, modulus and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      rr_ptr     <= '0;
      mod_reg    <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (bus.mod_ld_ack) mod_reg <= bus.mod_in;
      if (grant) begin
        rsp_id_q   <= winner;
        rsp_data_q <= core_result;
        rr_ptr     <= (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);
      end
    end
  end

  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

`ifdef MODARITH_RANGE_CHK_EN
  logic rsp_err_q;

  // Range flag is captured with the result and held with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err_q <= 1'b0;
    end else if (grant) begin
      rsp_err_q <= (a_sel >= mod_reg) | (b_sel >= mod_reg);
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_modarith_arbiter.sv
// tb_modarith_arbiter
// Directed bench for modarith_arbiter with DATA_WIDTH=8, NUM_REQ=4, M=97.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// there too, so combinational grants/acks and registered results are both
// observed away from the active edge.
module tb_modarith_arbiter;
  import modarith_pkg::*;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic [NR-1:0] valid;
  logic [NR-1:0] ops;
  logic [DW-1:0] a_arr [NR];
  logic [DW-1:0] b_arr [NR];

  modarith_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(IW)) bus ();

  modarith_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.req_valid = valid;
  assign bus.req_op    = ops;
  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign bus.req_a[g*DW +: DW] = a_arr[g];
    assign bus.req_b[g*DW +: DW] = b_arr[g];
  end

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [IW-1:0] idx, input logic op,
                               input logic [DW-1:0] a, input logic [DW-1:0] b);
    valid[idx] = 1'b1;
    ops[idx]   = op;
    a_arr[idx] = a;
    b_arr[idx] = b;
  endtask

  // Single-requester operation with rsp_ready high: grant, result, drain.
  task automatic doOp(input logic [IW-1:0] idx, input logic op,
                      input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] expected);
    applyStimulus(idx, op, a, b);
    #1;
    checkOutput("op_grant", 32'(bus.req_ready), 32'(4'b0001 << idx));
    tick();
    valid = '0;
    checkOutput("op_valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("op_id", 32'(bus.rsp_id), 32'(idx));
    checkOutput("op_data", 32'(bus.rsp_data), 32'(expected));
    checkOutput("op_err", 32'(bus.rsp_err), 32'd0);
    tick();
  endtask

  initial begin
    rst           = 1'b1;
    valid         = '0;
    ops           = '0;
    for (int i = 0; i < NR; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    bus.mod_ld    = 1'b0;
    bus.mod_in    = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();

    // Reset state; grants and acks must stay low while rst is high.
    valid      = 4'b1111;
    bus.mod_ld = 1'b1;
    bus.mod_in = 8'd97;
    #1;
    checkOutput("rst_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_id", 32'(bus.rsp_id), 32'd0);
    checkOutput("rst_data", 32'(bus.rsp_data), 32'd0);
    checkOutput("rst_err", 32'(bus.rsp_err), 32'd0);
    checkOutput("rst_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_ack", 32'(bus.mod_ld_ack), 32'd0);
    tick();

    // Modulus load from EMPTY is acknowledged in the same cycle.
    rst   = 1'b0;
    valid = '0;
    #1;
    checkOutput("ld_ack", 32'(bus.mod_ld_ack), 32'd1);
    checkOutput("ld_ready", 32'(bus.req_ready), 32'd0);
    tick();
    bus.mod_ld    = 1'b0;
    bus.rsp_ready = 1'b1;

    // Directed arithmetic vectors, M=97.
    doOp(2'd0, OP_SUB, 8'd10, 8'd20, 8'd87);
    doOp(2'd2, OP_ADD, 8'd90, 8'd20, 8'd13);
    doOp(2'd1, OP_ADD, 8'd40, 8'd50, 8'd90);
    doOp(2'd0, OP_SUB, 8'd0,  8'd96, 8'd1);
    doOp(2'd3, OP_SUB, 8'd33, 8'd33, 8'd0);

    // All requesters valid: round robin 0,1,2,3,0,1 with back-to-back results.
    for (int i = 0; i < NR; i++) begin
      a_arr[i] = DW'(i * 10);
      b_arr[i] = DW'(i + 1);
    end
    ops   = {NR{OP_ADD}};
    valid = 4'b1111;
    #1;
    for (int k = 0; k < 6; k++) begin
      checkOutput("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
      if (k > 0) begin
        checkOutput("rr_id", 32'(bus.rsp_id), 32'((k - 1) % 4));
        checkOutput("rr_data", 32'(bus.rsp_data), 32'(11 * ((k - 1) % 4) + 1));
      end
      tick();
    end
    checkOutput("rr_last_id", 32'(bus.rsp_id), 32'd1);
    checkOutput("rr_last_data", 32'(bus.rsp_data), 32'd12);

    // Backpressure: no grants, result held stable.
    bus.rsp_ready = 1'b0;
    #1;
    checkOutput("stall_ready", 32'(bus.req_ready), 32'd0);
    for (int s = 0; s < 3; s++) begin
      tick();
      checkOutput("stall_valid", 32'(bus.rsp_valid), 32'd1);
      checkOutput("stall_id", 32'(bus.rsp_id), 32'd1);
      checkOutput("stall_data", 32'(bus.rsp_data), 32'd12);
      checkOutput("stall_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput("resume_grant", 32'(bus.req_ready), 32'd4);
    tick();
    checkOutput("resume_id", 32'(bus.rsp_id), 32'd2);
    checkOutput("resume_data", 32'(bus.rsp_data), 32'd23);
    valid = '0;
    tick();

    // Modulus reload while FULL: held result keeps old M, ack after drain.
    bus.rsp_ready = 1'b0;
    applyStimulus(2'd0, OP_ADD, 8'd90, 8'd20);
    #1;
    checkOutput("hold_grant", 32'(bus.req_ready), 32'd1);
    tick();
    valid         = '0;
    bus.mod_ld    = 1'b1;
    bus.mod_in    = 8'd89;
    bus.rsp_ready = 1'b1;
    applyStimulus(2'd1, OP_SUB, 8'd10, 8'd20);
    #1;
    checkOutput("reload_ack_full", 32'(bus.mod_ld_ack), 32'd0);
    checkOutput("reload_ready_full", 32'(bus.req_ready), 32'd0);
    checkOutput("reload_old_data", 32'(bus.rsp_data), 32'd13);
    tick();
    checkOutput("reload_drained", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reload_ack", 32'(bus.mod_ld_ack), 32'd1);
    checkOutput("reload_ready", 32'(bus.req_ready), 32'd0);
    tick();
    bus.mod_ld = 1'b0;
    #1;
    checkOutput("newm_grant", 32'(bus.req_ready), 32'd2);
    tick();
    valid = '0;
    checkOutput("newm_id", 32'(bus.rsp_id), 32'd1);
    checkOutput("newm_data", 32'(bus.rsp_data), 32'd79);

    // Reset while FULL with pending requests discards everything.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) begin
      a_arr[i] = DW'(i * 10);
      b_arr[i] = DW'(i + 1);
    end
    ops   = {NR{OP_ADD}};
    valid = 4'b1111;
    rst   = 1'b1;
    #1;
    checkOutput("midrst_ready", 32'(bus.req_ready), 32'd0);
    tick();
    checkOutput("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("midrst_data", 32'(bus.rsp_data), 32'd0);
    checkOutput("midrst_id", 32'(bus.rsp_id), 32'd0);
    rst        = 1'b0;
    bus.mod_ld = 1'b1;
    bus.mod_in = 8'd97;
    #1;
    checkOutput("midrst_ack", 32'(bus.mod_ld_ack), 32'd1);
    checkOutput("midrst_ld_ready", 32'(bus.req_ready), 32'd0);
    tick();
    bus.mod_ld    = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput("midrst_first_grant", 32'(bus.req_ready), 32'd1);
    tick();
    checkOutput("midrst_first_id", 32'(bus.rsp_id), 32'd0);
    checkOutput("midrst_first_data", 32'(bus.rsp_data), 32'd1);
    valid = '0;
    tick();

    // Out-of-range operand: flagged only when range checking is built in.
    applyStimulus(2'd0, OP_ADD, 8'd97, 8'd1);
    #1;
    checkOutput("range_grant", 32'(bus.req_ready), 32'd1);
    tick();
    valid = '0;
    checkOutput("range_data", 32'(bus.rsp_data), 32'd1);
`ifdef MODARITH_RANGE_CHK_EN
    checkOutput("range_err", 32'(bus.rsp_err), 32'd1);
`else
    checkOutput("range_err", 32'(bus.rsp_err), 32'd0);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
